// File: rtl/page_table_walker_responder.sv
// page_table_walker_responder
//   Shared page-table walk engine serving the 8B (5-bit VPN) and 32B (3-bit VPN)
//   lookup channels of the speculative TLB. Round-robin arbitration between the
//   channels, programmable walk latency, one insert port for loading both tables.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   PAGE_8B_RQST/LOOKUP           8B request and VPN (held until COMPLETE seen)
//   PAGE_8B_RECV/COMPLETE/FAULT   8B response {VPN,PPN}, valid, invalid-entry flag
//   PAGE_32B_*                    same for the 32B channel
//   PT_INSERT_*                   single-cycle table write (SEL: 0=8B, 1=32B)
//   BUSY                          engine not idle
module page_table_walker_responder #(
  parameter int LOOKUP_LATENCY = 4,
  parameter int PT_8B_ENTRIES  = 32,
  parameter int PT_32B_ENTRIES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PAGE_8B_RQST,
  input  logic [4:0] PAGE_8B_LOOKUP,
  output logic [9:0] PAGE_8B_RECV,
  output logic       PAGE_8B_COMPLETE,
  output logic       PAGE_8B_FAULT,
  input  logic       PAGE_32B_RQST,
  input  logic [2:0] PAGE_32B_LOOKUP,
  output logic [5:0] PAGE_32B_RECV,
  output logic       PAGE_32B_COMPLETE,
  output logic       PAGE_32B_FAULT,
  input  logic       PT_INSERT_RQST,
  input  logic       PT_INSERT_SEL,
  input  logic [4:0] PT_INSERT_INDX,
  input  logic [4:0] PT_INSERT_PPN,
  input  logic       PT_INSERT_VALID,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

  // The counter is loaded with the full latency and the table is read on the
  // edge after it reaches zero, so COMPLETE rises LOOKUP_LATENCY+1 edges after
  // the grant edge.
  localparam logic [3:0] WALK_CYCLES = LOOKUP_LATENCY[3:0];

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;      // 1 = 32B preferred on the next tie
  logic       chan_q, chan_d;  // granted channel: 0 = 8B, 1 = 32B
  logic [4:0] vpn_q, vpn_d;
  logic [9:0] recv8_q, recv8_d;
  logic       cmp8_q, cmp8_d, flt8_q, flt8_d;
  logic [5:0] recv32_q, recv32_d;
  logic       cmp32_q, cmp32_d, flt32_q, flt32_d;
  logic       busy_q, busy_d;

  logic [4:0]                pt8_ppn_q  [PT_8B_ENTRIES];
  logic [4:0]                pt8_ppn_d  [PT_8B_ENTRIES];
  logic [PT_8B_ENTRIES-1:0]  pt8_vld_q, pt8_vld_d;
  logic [2:0]                pt32_ppn_q [PT_32B_ENTRIES];
  logic [2:0]                pt32_ppn_d [PT_32B_ENTRIES];
  logic [PT_32B_ENTRIES-1:0] pt32_vld_q, pt32_vld_d;

  logic req_granted;
  logic grant_32;
  logic rd_vld8, rd_vld32;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    chan_d     = chan_q;
    vpn_d      = vpn_q;
    recv8_d    = recv8_q;
    cmp8_d     = cmp8_q;
    flt8_d     = flt8_q;
    recv32_d   = recv32_q;
    cmp32_d    = cmp32_q;
    flt32_d    = flt32_q;
    pt8_ppn_d  = pt8_ppn_q;
    pt8_vld_d  = pt8_vld_q;
    pt32_ppn_d = pt32_ppn_q;
    pt32_vld_d = pt32_vld_q;
    grant_32   = PAGE_32B_RQST && (!PAGE_8B_RQST || rr_q);
    req_granted = chan_q ? PAGE_32B_RQST : PAGE_8B_RQST;
    rd_vld8    = pt8_vld_q[vpn_q];
    rd_vld32   = pt32_vld_q[vpn_q[2:0]];

    unique case (state_q)
      IDLE: begin
        if (PAGE_8B_RQST || PAGE_32B_RQST) begin
          chan_d  = grant_32;
          vpn_d   = grant_32 ? {2'b00, PAGE_32B_LOOKUP} : PAGE_8B_LOOKUP;
          cnt_d   = WALK_CYCLES;
          rr_d    = !grant_32;
          state_d = WALK;
        end
      end
      WALK: begin
        if (!req_granted) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          // Reads use the registered tables, so an insert on this same edge
          // is not visible to this walk.
          if (!chan_q) begin
            cmp8_d  = 1'b1;
            flt8_d  = !rd_vld8;
            recv8_d = {vpn_q, rd_vld8 ? pt8_ppn_q[vpn_q] : 5'd0};
          end else begin
            cmp32_d  = 1'b1;
            flt32_d  = !rd_vld32;
            recv32_d = {vpn_q[2:0], rd_vld32 ? pt32_ppn_q[vpn_q[2:0]] : 3'd0};
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (!req_granted) begin
          recv8_d  = '0;
          cmp8_d   = 1'b0;
          flt8_d   = 1'b0;
          recv32_d = '0;
          cmp32_d  = 1'b0;
          flt32_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    if (PT_INSERT_RQST) begin
      if (!PT_INSERT_SEL) begin
        pt8_ppn_d[PT_INSERT_INDX] = PT_INSERT_PPN;
        pt8_vld_d[PT_INSERT_INDX] = PT_INSERT_VALID;
      end else begin
        pt32_ppn_d[PT_INSERT_INDX[2:0]] = PT_INSERT_PPN[2:0];
        pt32_vld_d[PT_INSERT_INDX[2:0]] = PT_INSERT_VALID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      chan_q     <= 1'b0;
      recv8_q    <= '0;
      cmp8_q     <= 1'b0;
      flt8_q     <= 1'b0;
      recv32_q   <= '0;
      cmp32_q    <= 1'b0;
      flt32_q    <= 1'b0;
      busy_q     <= 1'b0;
      pt8_vld_q  <= '0;
      pt32_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      chan_q     <= chan_d;
      recv8_q    <= recv8_d;
      cmp8_q     <= cmp8_d;
      flt8_q     <= flt8_d;
      recv32_q   <= recv32_d;
      cmp32_q    <= cmp32_d;
      flt32_q    <= flt32_d;
      busy_q     <= busy_d;
      pt8_vld_q  <= pt8_vld_d;
      pt32_vld_q <= pt32_vld_d;
    end
  end

  // Payload state: VPN latch and PPN storage need no reset.
  always_ff @(posedge clk) begin
    vpn_q      <= vpn_d;
    pt8_ppn_q  <= pt8_ppn_d;
    pt32_ppn_q <= pt32_ppn_d;
  end

  assign PAGE_8B_RECV      = recv8_q;
  assign PAGE_8B_COMPLETE  = cmp8_q;
  assign PAGE_8B_FAULT     = flt8_q;
  assign PAGE_32B_RECV     = recv32_q;
  assign PAGE_32B_COMPLETE = cmp32_q;
  assign PAGE_32B_FAULT    = flt32_q;
  assign BUSY              = busy_q;

endmodule

// File: tb/tb_page_table_walker_responder.sv
module tb_page_table_walker_responder;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rq8, rq32;
  logic [4:0] lk8;
  logic [2:0] lk32;
  logic       ins, ins_sel, ins_v;
  logic [4:0] ins_idx, ins_ppn;
  logic [9:0] r8;
  logic [5:0] r32;
  logic       c8, f8, c32, f32, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  page_table_walker_responder #(.LOOKUP_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .PAGE_8B_RQST(rq8), .PAGE_8B_LOOKUP(lk8), .PAGE_8B_RECV(r8),
    .PAGE_8B_COMPLETE(c8), .PAGE_8B_FAULT(f8),
    .PAGE_32B_RQST(rq32), .PAGE_32B_LOOKUP(lk32), .PAGE_32B_RECV(r32),
    .PAGE_32B_COMPLETE(c32), .PAGE_32B_FAULT(f32),
    .PT_INSERT_RQST(ins), .PT_INSERT_SEL(ins_sel), .PT_INSERT_INDX(ins_idx),
    .PT_INSERT_PPN(ins_ppn), .PT_INSERT_VALID(ins_v), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: tables as arrays, a walk is a timestamped grant
  // that responds LAT+1 edges later unless its request drops first.
  logic [4:0] mt8_ppn [32];
  bit         mt8_v   [32];
  logic [2:0] mt32_ppn [8];
  bit         mt32_v   [8];
  int         m_mode = 0;   // 0 idle, 1 walking, 2 responding
  int         m_ch = 0, m_last = 1, m_start = 0, cyc = 0;
  logic [4:0] m_vpn;
  logic [9:0] e_r8 = '0;
  logic [5:0] e_r32 = '0;
  bit         e_c8, e_f8, e_c32, e_f32, e_busy;

  always @(posedge clk) begin
    bit req;
    int g;
    if (!rst_n) begin
      m_mode = 0; m_last = 1;
      for (int i = 0; i < 32; i++) mt8_v[i] = 0;
      for (int i = 0; i < 8; i++) mt32_v[i] = 0;
      e_r8 = '0; e_r32 = '0; e_c8 = 0; e_f8 = 0; e_c32 = 0; e_f32 = 0;
    end else begin
      req = (m_ch == 0) ? rq8 : rq32;
      if (m_mode == 0) begin
        g = -1;
        if (rq8 && rq32) g = (m_last == 0) ? 1 : 0;
        else if (rq8)    g = 0;
        else if (rq32)   g = 1;
        if (g >= 0) begin
          m_ch = g; m_last = g; m_start = cyc; m_mode = 1;
          m_vpn = (g == 0) ? lk8 : {2'b00, lk32};
        end
      end else if (m_mode == 1) begin
        if (!req) m_mode = 0;
        else if (cyc - m_start == LAT + 1) begin
          m_mode = 2;
          if (m_ch == 0) begin
            e_c8 = 1; e_f8 = !mt8_v[m_vpn];
            e_r8 = {m_vpn, mt8_v[m_vpn] ? mt8_ppn[m_vpn] : 5'd0};
          end else begin
            e_c32 = 1; e_f32 = !mt32_v[m_vpn[2:0]];
            e_r32 = {m_vpn[2:0], mt32_v[m_vpn[2:0]] ? mt32_ppn[m_vpn[2:0]] : 3'd0};
          end
        end
      end else if (!req) begin
        m_mode = 0;
        e_r8 = '0; e_r32 = '0; e_c8 = 0; e_f8 = 0; e_c32 = 0; e_f32 = 0;
      end
      if (ins) begin
        if (!ins_sel) begin mt8_ppn[ins_idx] = ins_ppn; mt8_v[ins_idx] = ins_v; end
        else begin mt32_ppn[ins_idx[2:0]] = ins_ppn[2:0]; mt32_v[ins_idx[2:0]] = ins_v; end
      end
    end
    e_busy = (m_mode != 0);
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, c8, f8, r8, c32, f32, r32} !== {e_busy, e_c8, e_f8, e_r8, e_c32, e_f32, e_r32}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got busy=%b c8=%b f8=%b r8=%h c32=%b f32=%b r32=%b want busy=%b c8=%b f8=%b r8=%h c32=%b f32=%b r32=%b",
                 $time, busy, c8, f8, r8, c32, f32, r32, e_busy, e_c8, e_f8, e_r8, e_c32, e_f32, e_r32);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert(input logic sel, input logic [4:0] idx, input logic [4:0] ppn, input logic v);
    ins = 1; ins_sel = sel; ins_idx = idx; ins_ppn = ppn; ins_v = v;
    step();
    ins = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rq8 = 0; rq32 = 0; lk8 = '0; lk32 = '0;
    ins = 0; ins_sel = 0; ins_idx = '0; ins_ppn = '0; ins_v = 0;
    step(2);
    rst_n = 1;
    chk_en = 1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_c8", 32'(c8), 32'd0);
    chk("rst_r8", 32'(r8), 32'd0);
    chk("rst_r32", 32'(r32), 32'd0);

    // 8B hit with default latency
    insert(1'b0, 5'h13, 5'h0A, 1'b1);
    rq8 = 1; lk8 = 5'h13;
    step(5);
    chk("hit8_early_c8", 32'(c8), 32'd0);
    step();
    chk("hit8_c8", 32'(c8), 32'd1);
    chk("hit8_r8", 32'(r8), 32'h26A);
    chk("hit8_f8", 32'(f8), 32'd0);
    rq8 = 0;
    step();
    chk("hit8_drop_c8", 32'(c8), 32'd0);
    chk("hit8_drop_busy", 32'(busy), 32'd0);

    // 32B miss on a never-written entry
    rq32 = 1; lk32 = 3'd5;
    step(6);
    chk("miss32_c32", 32'(c32), 32'd1);
    chk("miss32_f32", 32'(f32), 32'd1);
    chk("miss32_r32", 32'(r32), 32'b101000);
    rq32 = 0;
    step();

    // Tie: 8B first, then 32B on the next tie
    rq8 = 1; lk8 = 5'h13; rq32 = 1; lk32 = 3'd3;
    step(6);
    chk("tie1_c8", 32'(c8), 32'd1);
    chk("tie1_c32", 32'(c32), 32'd0);
    rq8 = 0; rq32 = 0;
    step();
    rq8 = 1; rq32 = 1;
    step(6);
    chk("tie2_c32", 32'(c32), 32'd1);
    chk("tie2_c8", 32'(c8), 32'd0);
    chk("tie2_r32", 32'(r32), 32'b011000);
    rq8 = 0; rq32 = 0;
    step();

    // Abort mid-walk
    rq8 = 1; lk8 = 5'h13;
    step(2);
    rq8 = 0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    step(5);
    chk("abort_c8", 32'(c8), 32'd0);
    rq8 = 1;
    step(6);
    chk("after_abort_r8", 32'(r8), 32'h26A);
    rq8 = 0;
    step();

    // Insert colliding with the walk read: old value returned
    rq32 = 1; lk32 = 3'd3;
    step(5);
    ins = 1; ins_sel = 1; ins_idx = 5'd3; ins_ppn = 5'd6; ins_v = 1;
    step();
    ins = 0;
    chk("rbw_c32", 32'(c32), 32'd1);
    chk("rbw_f32", 32'(f32), 32'd1);
    rq32 = 0;
    step();
    rq32 = 1;
    step(6);
    chk("rbw2_r32", 32'(r32), 32'b011110);
    chk("rbw2_f32", 32'(f32), 32'd0);
    rq32 = 0;
    step();

    // Reset while responding
    rq8 = 1; lk8 = 5'h13;
    step(6);
    chk("pre_rst_c8", 32'(c8), 32'd1);
    rst_n = 0;
    step();
    chk("midrst_c8", 32'(c8), 32'd0);
    chk("midrst_r8", 32'(r8), 32'd0);
    rst_n = 1; rq8 = 0;
    step();
    rq8 = 1;
    step(6);
    chk("postrst_f8", 32'(f8), 32'd1);
    chk("postrst_r8", 32'(r8), 32'h260);
    rq8 = 0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
